// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcode and phase encodings,
// run/halt state type and the ALU-operation membership test.
package cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } run_state_e;

    // Instructions whose operand is read from memory and result lands in the accumulator.
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_phase_counter.sv
// Wrapping 3-bit instruction phase counter; advances when en is high and hold is low.
module cpu_phase_counter
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       hold,
    output logic [2:0] phase
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= PH_INST_ADDR;
        end else if (en && !hold) begin
            phase <= phase + 3'd1;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction-cycle control FSM: decodes phase/opcode/zero into datapath strobes.
// Optional single-step operation is enabled by defining CPU_SEQ_SINGLE_STEP_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | phase counter cycles 0..7, strobes decoded from phase/opcode
// ST_HALTED  | HLT executed; phase frozen at OP_FETCH, only halt asserted
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int OPC_W   = 3,
    parameter int PHASE_W = 3
) (
    input  logic               clk,
    input  logic               rst,
`ifdef CPU_SEQ_SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic [OPC_W-1:0]   opcode,
    input  logic               zero,
    output logic               sel,
    output logic               rd,
    output logic               ld_ir,
    output logic               inc_pc,
    output logic               ld_pc,
    output logic               ld_ac,
    output logic               wr,
    output logic               data_e,
    output logic               halt,
    output logic [PHASE_W-1:0] phase
);

    run_state_e state, state_next;
    logic       advance;
    logic       aluop;

`ifdef CPU_SEQ_SINGLE_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    assign aluop = is_aluop(opcode);

    cpu_phase_counter u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (advance),
        .hold  (state == ST_HALTED),
        .phase (phase)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sel        = 1'b0;
        rd         = 1'b0;
        ld_ir      = 1'b0;
        inc_pc     = 1'b0;
        ld_pc      = 1'b0;
        ld_ac      = 1'b0;
        wr         = 1'b0;
        data_e     = 1'b0;
        halt       = 1'b0;

        case (state)
            ST_RUN: begin
                if (advance && phase == PH_OP_ADDR && opcode == OP_HLT) begin
                    state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
`ifdef CPU_SEQ_SINGLE_STEP_EN
                if (step && opcode != OP_HLT) begin
                    state_next = ST_RUN;
                end
`endif
            end
            default: state_next = ST_RUN;
        endcase

        case (phase)
            PH_INST_ADDR: begin
                sel = 1'b1;
            end
            PH_INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (opcode == OP_HLT);
            end
            PH_OP_FETCH: begin
                rd = aluop;
            end
            PH_ALU_OP: begin
                rd     = aluop;
                inc_pc = (opcode == OP_SKZ) && zero;
                ld_pc  = (opcode == OP_JMP);
                data_e = (opcode == OP_STO);
            end
            PH_STORE: begin
                rd     = aluop;
                ld_ac  = aluop;
                ld_pc  = (opcode == OP_JMP);
                wr     = (opcode == OP_STO);
                data_e = (opcode == OP_STO);
            end
            default: ;
        endcase

        // A halted CPU must not touch memory, PC or accumulator.
        if (state == ST_HALTED) begin
            sel    = 1'b0;
            rd     = 1'b0;
            ld_ir  = 1'b0;
            inc_pc = 1'b0;
            ld_pc  = 1'b0;
            ld_ac  = 1'b0;
            wr     = 1'b0;
            data_e = 1'b0;
            halt   = 1'b1;
        end

`ifdef CPU_SEQ_SINGLE_STEP_EN
        if (!step) begin
            sel    = 1'b0;
            rd     = 1'b0;
            ld_ir  = 1'b0;
            inc_pc = 1'b0;
            ld_pc  = 1'b0;
            ld_ac  = 1'b0;
            wr     = 1'b0;
            data_e = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed, table-driven bench for cpu_sequencer with hand-computed strobe patterns.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    // Output vector order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
    localparam logic [8:0] O_P0   = 9'b100000000;
    localparam logic [8:0] O_P1   = 9'b110000000;
    localparam logic [8:0] O_P23  = 9'b111000000;
    localparam logic [8:0] O_P4   = 9'b000100000;
    localparam logic [8:0] O_NONE = 9'b000000000;
    localparam logic [8:0] O_HALT = 9'b000000001;

    typedef struct {
        logic [2:0] op;
        logic       z;
        logic [2:0] exp_phase;
        logic [8:0] exp_out;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       step;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0] phase;

    int compared   = 0;
    int mismatched = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk    (clk),
        .rst    (rst),
`ifdef CPU_SEQ_SINGLE_STEP_EN
        .step   (step),
`endif
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    function automatic logic [8:0] outs();
        return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
    endfunction

    task automatic check(input string name, input logic [2:0] ep, input logic [8:0] eo);
        compared++;
        if (phase !== ep || outs() !== eo) begin
            mismatched++;
            $display("FAIL %s: phase=%0d outs=%b, required phase=%0d outs=%b",
                     name, phase, outs(), ep, eo);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Eight rows for one instruction; during phases 0-3 the opcode is a
    // deliberately unrelated value since it must not matter there.
    task automatic add_instr(input logic [2:0] op, input logic [7:0] zpat,
                             input logic [8:0] e5, input logic [8:0] e6, input logic [8:0] e7);
        logic [8:0] exp_tab [8];
        exp_tab = '{O_P0, O_P1, O_P23, O_P23, O_P4, e5, e6, e7};
        for (int p = 0; p < 8; p++) begin
            vec_t v;
            v.op        = (p < 4) ? (op ^ 3'b101) : op;
            v.z         = zpat[p];
            v.exp_phase = 3'(p);
            v.exp_out   = exp_tab[p];
            vecs.push_back(v);
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = OP_ADD;
        zero   = 1'b0;
        step   = 1'b1;

        add_instr(OP_ADD, 8'b0000_0000, 9'b010000000, 9'b010000000, 9'b010001000);
        add_instr(OP_STO, 8'b0000_0000, O_NONE,       9'b000000010, 9'b000000110);
        add_instr(OP_SKZ, 8'b0100_0000, O_NONE,       9'b000100000, O_NONE);
        add_instr(OP_SKZ, 8'b1011_1111, O_NONE,       O_NONE,       O_NONE);
        add_instr(OP_JMP, 8'b1111_1111, O_NONE,       9'b000010000, 9'b000010000);
        add_instr(OP_LDA, 8'b0101_0101, 9'b010000000, 9'b010000000, 9'b010001000);
        add_instr(OP_XOR, 8'b0000_0000, 9'b010000000, 9'b010000000, 9'b010001000);

        #1;
        check("reset_state", 3'd0, O_P0);
        tick();
        tick();
        rst = 1'b0;

        foreach (vecs[i]) begin
            opcode = vecs[i].op;
            zero   = vecs[i].z;
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp_phase, vecs[i].exp_out);
            tick();
        end

        // Reset asserted mid-instruction at OP_FETCH.
        opcode = OP_ADD;
        zero   = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #1;
        check("pre_reset_p5", 3'd5, 9'b010000000);
        rst = 1'b1;
        #1;
        check("async_reset", 3'd0, O_P0);
        tick();
        check("reset_held", 3'd0, O_P0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            compared++;
            if (phase !== 3'((i + 1) % 8)) begin
                mismatched++;
                $display("FAIL reset_walk%0d: phase=%0d required=%0d", i, phase, (i + 1) % 8);
            end
        end

        // HLT: run to OP_ADDR, then the phase must freeze at OP_FETCH.
        while (phase != 3'd0) tick();
        opcode = OP_HLT;
        for (int i = 0; i < 4; i++) tick();
        #1;
        check("hlt_op_addr", 3'd4, 9'b000100001);
        tick();
        for (int i = 0; i < 20; i++) begin
            opcode = (i % 3 == 0) ? OP_ADD : OP_HLT;
            zero   = i[0];
            #1;
            check($sformatf("halted%0d", i), 3'd5, O_HALT);
            tick();
        end
        rst = 1'b1;
        #1;
        check("halt_reset", 3'd0, O_P0);
        tick();
        rst    = 1'b0;
        opcode = OP_ADD;
        tick();
        check("halt_reset_resume", 3'd1, O_P1);

`ifdef CPU_SEQ_SINGLE_STEP_EN
        rst = 1'b1;
        step = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("step_idle%0d", i), 3'(i), O_NONE);
            step = 1'b1;
            tick();
            step = 1'b0;
        end
        #1;
        check("step_done", 3'd3, O_NONE);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Instruction-cycle control FSM for the 8-bit accumulator CPU.
- Drives the 3-bit opcode-dependent control strobes for memory, PC, IR and accumulator.
- Consumes the ALU's zero flag for the skip-if-zero instruction.
- Acts as the master end of the ALU/datapath control interface: the ALU computes, and this block decides when results are loaded, stored, skipped or jumped to.

Parameters:
- OPC_W, 3, opcode width; fixed encoding, must stay 3.
- PHASE_W, 3, phase register width; 8 phases, must stay 3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: asynchronous, active-high.
- opcode  in  OPC_W  current IR opcode: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- zero  in  1  accumulator-is-zero flag from the ALU.
- sel  out  1  address mux select: 1 = PC, 0 = IR operand.
- rd  out  1  memory read enable.
- ld_ir  out  1  load instruction register.
- inc_pc  out  1  increment PC.
- ld_pc  out  1  load PC from IR operand.
- ld_ac  out  1  load accumulator from ALU output.
- wr  out  1  memory write strobe.
- data_e  out  1  accumulator drives data bus.
- halt  out  1  CPU halted.
- phase  out  PHASE_W  current phase, for debug and test.

Behaviour:
- Phase register encoding: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- Phase increments by 1 every clk; 7 wraps to 0.
- One instruction takes exactly 8 cycles.
- Control outputs are a combinational decode of phase, opcode and zero; no added latency. Phase is registered.
- Define ALUOP = ADD | AND | XOR | LDA.
- Decode per phase (any strobe not listed is 0):
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1, ld_ir=1.
  - OP_ADDR: inc_pc=1; halt=1 if opcode==HLT.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
- Halt:
  - A halted flag sets on the clk edge leaving OP_ADDR with opcode==HLT.
  - While halted, phase freezes at OP_FETCH (5).
  - While halted, halt=1 and all other strobes are 0.
  - Only rst clears the halted state.
- zero is sampled only in ALU_OP; it is ignored in all other phases.
- opcode is ignored during phases 0-3.
- Reset values (rst asserted, including mid-instruction):
  - phase=0 and halted=0 immediately.
  - Outputs take the INST_ADDR decode: sel=1, all others 0, phase=0.
- First rising edge after rst deasserts moves phase to 1.
- wr and ld_pc are never asserted outside ALU_OP/STORE; the decode enforces this.

Optional Feature:
- Macro: CPU_SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input `step` (1 bit).
  - Phase advances only on clk edges where step==1.
  - Strobes are gated to 0 when step==0, so each step pulse executes exactly one phase.
  - The halted flag also clears on a step pulse coinciding with opcode!=HLT.
- When undefined:
  - No step port.
  - Phase advances every clk as above.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams OP_HLT..OP_JMP (3-bit).
  - phase localparams PH_INST_ADDR..PH_STORE.
  - the ALUOP membership function, shared with the ALU bench.
- One natural sub-module: cpu_phase_counter.
  - Contents: the 3-bit wrapping counter with async reset, hold (halt) and optional step enable.
  - The decode stays in cpu_sequencer.

Test Plan:
- Reset mid-phase: assert rst at phase 5 with opcode=ADD → phase=0, sel=1, rd/ld_ac/wr=0 immediately without a clock edge; after release phase reads 1,2,…,7,0 on successive edges.
- ADD instruction (opcode=2) over 8 cycles:
  - rd=1 in phases 1,2,3,5,6,7.
  - ld_ir=1 in phases 2,3 only.
  - inc_pc=1 in phase 4 only.
  - ld_ac=1 in phase 7 only.
  - wr=0 throughout.
- STO (opcode=6): data_e=1 in phases 6,7; wr=1 in phase 7 only; rd=0 in phases 5-7; ld_ac=0.
- SKZ (opcode=1):
  - zero=1: inc_pc=1 in phases 4 and 6.
  - zero=0: inc_pc=1 in phase 4 only.
  - Toggle zero in other phases → no effect.
- JMP (opcode=7): ld_pc=1 in phases 6,7; inc_pc=1 in phase 4 only; ld_ac=0.
- HLT (opcode=0): halt rises in phase 4; phase stays 5 for 20 cycles with all other strobes 0; rst → phase=0, halt=0.
- Single-step build only: step pulses 3 times → phase 0→3; strobes are 0 on cycles with step=0.
